ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
Pipelined, parametrised control unit for the RV32I(+M) core. It decodes opcode/func3/func7 into a registered control word for the execute stage: imm_type, ALU mux selects, rd_sel, alu_op, reg_wr and we. It adds sequential hazard logic: load-use stall, multi-cycle divide stall and branch/jump redirect flush. It sits between fetch/decode and the imm_mux/alu1_mux/alu2_mux/rd_mux/alu datapath.

Parameters:
LOAD_LAT, 1, number of stall cycles inserted on a load-use hazard (legal range 1..7).
EN_M, 1, 1 = decode the M extension; 0 = func7=0000001 on OP is illegal.
DIV_CYCLES, 8, total cycles a DIV/DIVU/REM/REMU occupies execute (legal range 2..63).
FLUSH_DEPTH, 1, number of consecutive input slots discarded after a redirect, counting the redirect cycle (legal range 1..3).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-low.
in_valid  in  1  decode slot holds an instruction.
in_ready  out  1  control unit accepts the slot this cycle.
opcode  in  5  inst[6:2].
func3  in  3  inst[14:12].
func7  in  7  inst[31:25].
rd/rs1/rs2  in  5 each  register indices of the decode-slot instruction.
b  in  1  comparator result for the branch currently in execute.
out_valid  out  1  execute control word commits this cycle.
imm_type  out  3  I=0, S=1, B=2, U=3, J=4, default=7.
alu1_sel  out  1  RS=0, PC=1.
alu2_sel  out  1  RS=0, IMM=1.
rd_sel  out  2  ALU=0, IMM=1, PCP4=2, MEM=3.
alu_op  out  4  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 MUL10 DIV11 DIVU12 REM13 REMU14 PASSB15.
reg_wr, we  out  1 each  register-file write, data-memory write.
pc_sel  out  1  1 = redirect PC to the ALU result.
flush  out  1  an input slot is being discarded this cycle.
illegal  out  1  the execute slot holds an undecodable instruction.

Behaviour:
- Opcode encodings: OP_IMM 00100, LUI 01101, AUIPC 00101, JAL 11011, JALR 11001, BRANCH 11000, LOAD 00000, STORE 01000, OP 01100.
- Decode per opcode:
  - imm_type: OP_IMM/JALR/LOAD→I; STORE→S; BRANCH→B; LUI/AUIPC→U; JAL→J; otherwise 7.
  - alu1_sel: BRANCH/JAL/AUIPC→PC; otherwise RS.
  - alu2_sel: OP→RS; otherwise IMM.
  - rd_sel: JAL/JALR→PCP4; LOAD→MEM; LUI→IMM; otherwise ALU.
  - alu_op: from func3 for OP/OP_IMM. SUB only for OP with func7=0100000. SRA for func3=101 with func7[5]=1. OP with func7=0000001 maps func3 0..3→MUL, func3 4..7→DIV, DIVU, REM, REMU. LUI→PASSB. All other opcodes→ADD.
  - reg_wr=1 for OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD. we=1 for STORE.
- Latency: a slot accepted (in_valid&in_ready) at edge N drives the outputs from edge N to edge N+1. Exception: divides, see below.
- Bubble: the execute register loads out_valid=0, reg_wr=0, we=0, illegal=0. The other fields hold their reset values.
- Unknown opcode, or func7=0000001 with EN_M=0: the slot is accepted, execute loads a bubble with illegal=1.
- State machine with states RUN, LD_WAIT and DIV_BUSY. A 6-bit counter cnt is shared by the stall states.
- RUN, load-use hazard:
  - Condition: out_valid=1, execute holds LOAD with rd≠0, and the slot instruction reads that rd (rs1 for all but LUI/AUIPC/JAL; rs2 for OP/STORE/BRANCH).
  - Response: in_ready=0, execute loads a bubble, cnt=LOAD_LAT-1, go to LD_WAIT if LOAD_LAT>1, else stay in RUN.
- LD_WAIT: in_ready=0 and a bubble is loaded each cycle. cnt decrements; when cnt=0, go to RUN. Exactly LOAD_LAT stall cycles total.
- RUN, divide accepted:
  - Execute latches the divide with out_valid=0, cnt=DIV_CYCLES-2, go to DIV_BUSY.
- DIV_BUSY: in_ready=0. At cnt=0, out_valid=1 for one cycle, then return to RUN. The slot is accepted again that cycle if in_valid.
- Redirect:
  - Trigger: out_valid=1 and (JAL, JALR, or BRANCH with b=1). pc_sel=1 combinationally from the execute register.
  - That cycle plus the next FLUSH_DEPTH-1 cycles form the flush window: flush=1, in_ready=1, incoming slots are discarded as bubbles.
- Priority: flush > load-use hazard > divide start. A discarded slot never stalls and never starts a divide.
- rst=0 at an edge:
  - Returns to RUN with cnt=0 and a cleared flush window, aborting any stall or divide.
  - Outputs: out_valid=0, reg_wr=0, we=0, pc_sel=0, flush=0, illegal=0, imm_type=7, alu1_sel=0, alu2_sel=1, rd_sel=0, alu_op=0.
  - in_ready=0 while rst=0.

Test Plan:
- Reset then ADDI (opcode 00100, func3 000): the next cycle has out_valid=1, imm_type=0, alu2_sel=1, rd_sel=0, alu_op=0, reg_wr=1.
- LOAD rd=5 followed by ADD rs1=5, LOAD_LAT=2: in_ready=0 for 2 cycles with out_valid=0, then ADD commits with alu_op=0, alu2_sel=0.
- DIVU (func7 0000001, func3 101), DIV_CYCLES=8: in_ready=0 for 7 cycles, out_valid=1 with alu_op=12 on the 8th; with EN_M=0 the response is instead illegal=1, reg_wr=0.
- BRANCH in execute with b=1, FLUSH_DEPTH=2: pc_sel=1, flush=1 for 2 cycles, and both younger slots produce out_valid=0. With b=0: pc_sel=0, no flush.
- Redirect cycle coinciding with a load-use slot: flush wins, in_ready=1, no LD_WAIT entry.
- rst=0 on the 4th DIV_BUSY cycle: the next cycle shows state RUN and all outputs at reset values; after release, SUB (func7 0100000) decodes to alu_op=1.

Source files
------------

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// ctrl_pipe - registered RV32I(+M) execute control word with load-use stall,
//             multi-cycle divide stall and branch/jump redirect flush.
// Revision 1.0
// ============================================================================
module ctrl_pipe #(
  parameter int LOAD_LAT    = 1,
  parameter int EN_M        = 1,
  parameter int DIV_CYCLES  = 8,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       b,
  output logic       out_valid,
  output logic [2:0] imm_type,
  output logic       alu1_sel,
  output logic       alu2_sel,
  output logic [1:0] rd_sel,
  output logic [3:0] alu_op,
  output logic       reg_wr,
  output logic       we,
  output logic       pc_sel,
  output logic       flush,
  output logic       illegal
);

  localparam logic [4:0] c_op_imm = 5'b00100;
  localparam logic [4:0] c_lui    = 5'b01101;
  localparam logic [4:0] c_auipc  = 5'b00101;
  localparam logic [4:0] c_jal    = 5'b11011;
  localparam logic [4:0] c_jalr   = 5'b11001;
  localparam logic [4:0] c_branch = 5'b11000;
  localparam logic [4:0] c_load   = 5'b00000;
  localparam logic [4:0] c_store  = 5'b01000;
  localparam logic [4:0] c_op     = 5'b01100;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_WAIT  = 2'd1,
    DIV_BUSY = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] imm_type;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [1:0] rd_sel;
    logic [3:0] alu_op;
    logic       reg_wr;
    logic       we;
    logic       illegal;
    logic       is_load;
    logic       is_jump;
    logic       is_branch;
    logic [4:0] rd;
  } ex_t;

  localparam ex_t c_bubble = '{valid: 1'b0, imm_type: 3'd7, alu1_sel: 1'b0,
                               alu2_sel: 1'b1, rd_sel: 2'd0, alu_op: 4'd0,
                               reg_wr: 1'b0, we: 1'b0, illegal: 1'b0,
                               is_load: 1'b0, is_jump: 1'b0, is_branch: 1'b0,
                               rd: 5'd0};

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] fcnt_q, fcnt_d;
  ex_t        ex_q, ex_d;

  ex_t        w_dec;
  logic       w_ill;
  logic       w_div;
  logic [3:0] w_f3_op;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_hazard;
  logic       w_muldiv;

  assign w_muldiv = (opcode == c_op) && (func7 == 7'b0000001);

  always_comb begin
    w_f3_op = 4'd0;
    case (func3)
      3'd0:    w_f3_op = (opcode == c_op && func7 == 7'b0100000) ? 4'd1 : 4'd0;
      3'd1:    w_f3_op = 4'd2;
      3'd2:    w_f3_op = 4'd3;
      3'd3:    w_f3_op = 4'd4;
      3'd4:    w_f3_op = 4'd5;
      3'd5:    w_f3_op = func7[5] ? 4'd7 : 4'd6;
      3'd6:    w_f3_op = 4'd8;
      default: w_f3_op = 4'd9;
    endcase
  end

  always_comb begin
    w_dec       = c_bubble;
    w_dec.valid = 1'b1;
    w_dec.rd    = rd;
    w_ill       = 1'b0;
    w_div       = 1'b0;
    case (opcode)
      c_op_imm: begin w_dec.imm_type = 3'd0; w_dec.alu_op = w_f3_op; w_dec.reg_wr = 1'b1; end
      c_lui:    begin w_dec.imm_type = 3'd3; w_dec.rd_sel = 2'd1; w_dec.alu_op = 4'd15; w_dec.reg_wr = 1'b1; end
      c_auipc:  begin w_dec.imm_type = 3'd3; w_dec.alu1_sel = 1'b1; w_dec.reg_wr = 1'b1; end
      c_jal: begin
        w_dec.imm_type = 3'd4; w_dec.alu1_sel = 1'b1; w_dec.rd_sel = 2'd2;
        w_dec.reg_wr   = 1'b1; w_dec.is_jump  = 1'b1;
      end
      c_jalr:   begin w_dec.imm_type = 3'd0; w_dec.rd_sel = 2'd2; w_dec.reg_wr = 1'b1; w_dec.is_jump = 1'b1; end
      c_branch: begin w_dec.imm_type = 3'd2; w_dec.alu1_sel = 1'b1; w_dec.is_branch = 1'b1; end
      c_load:   begin w_dec.imm_type = 3'd0; w_dec.rd_sel = 2'd3; w_dec.reg_wr = 1'b1; w_dec.is_load = 1'b1; end
      c_store:  begin w_dec.imm_type = 3'd1; w_dec.we = 1'b1; end
      c_op: begin
        w_dec.alu2_sel = 1'b0;
        w_dec.reg_wr   = 1'b1;
        w_dec.alu_op   = w_f3_op;
        if (w_muldiv) begin
          if (EN_M == 0) begin
            w_ill = 1'b1;
          end else begin
            // func3[2] selects DIV/DIVU/REM/REMU (11..14); lower codes all map to MUL
            w_div        = func3[2];
            w_dec.alu_op = func3[2] ? (4'd11 + {2'b00, func3[1:0]}) : 4'd10;
          end
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_use_rs1 = !(opcode == c_lui || opcode == c_auipc || opcode == c_jal);
  assign w_use_rs2 = (opcode == c_op) || (opcode == c_store) || (opcode == c_branch);
  assign w_hazard  = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) && in_valid &&
                     ((w_use_rs1 && rs1 == ex_q.rd) || (w_use_rs2 && rs2 == ex_q.rd));

  assign out_valid = ex_q.valid;
  assign imm_type  = ex_q.imm_type;
  assign alu1_sel  = ex_q.alu1_sel;
  assign alu2_sel  = ex_q.alu2_sel;
  assign rd_sel    = ex_q.rd_sel;
  assign alu_op    = ex_q.alu_op;
  assign reg_wr    = ex_q.reg_wr;
  assign we        = ex_q.we;
  assign illegal   = ex_q.illegal;
  assign pc_sel    = ex_q.valid && (ex_q.is_jump || (ex_q.is_branch && b));
  assign flush     = pc_sel || (fcnt_q != 2'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    ex_d     = ex_q;
    in_ready = 1'b0;
    if (pc_sel) begin
      fcnt_d = 2'(FLUSH_DEPTH - 1);
    end else if (fcnt_q != 2'd0) begin
      fcnt_d = fcnt_q - 2'd1;
    end
    case (state_q)
      RUN: begin
        ex_d = c_bubble;
        if (flush) begin
          in_ready = 1'b1;
        end else if (w_hazard) begin
          cnt_d = 6'(LOAD_LAT - 1);
          if (LOAD_LAT > 1) state_d = LD_WAIT;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (w_ill) begin
              ex_d.illegal = 1'b1;
            end else if (w_div) begin
              // divide sits in execute uncommitted until the countdown expires
              ex_d       = w_dec;
              ex_d.valid = 1'b0;
              cnt_d      = 6'(DIV_CYCLES - 2);
              state_d    = DIV_BUSY;
            end else begin
              ex_d = w_dec;
            end
          end
        end
      end
      LD_WAIT: begin
        ex_d  = c_bubble;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q <= 6'd1) state_d = RUN;
      end
      DIV_BUSY: begin
        if (cnt_q == 6'd0) begin
          ex_d.valid = 1'b1;
          state_d    = RUN;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        ex_d    = c_bubble;
        state_d = RUN;
      end
    endcase
    if (!rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 6'd0;
      fcnt_q  <= 2'd0;
      ex_q    <= c_bubble;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      ex_q    <= ex_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// tb_ctrl_pipe - directed bench for ctrl_pipe with a commit scoreboard.
// Revision 1.0
// ============================================================================
module tb_ctrl_pipe;

  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  typedef logic [12:0] cw_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [4:0] rd, rs1, rs2;
  logic       b;

  logic       in_ready, out_valid, alu1_sel, alu2_sel, reg_wr, we, pc_sel, flush, illegal;
  logic [2:0] imm_type;
  logic [1:0] rd_sel;
  logic [3:0] alu_op;

  logic       m0_in_ready, m0_out_valid, m0_alu1_sel, m0_alu2_sel, m0_reg_wr, m0_we;
  logic       m0_pc_sel, m0_flush, m0_illegal;
  logic [2:0] m0_imm_type;
  logic [1:0] m0_rd_sel;
  logic [3:0] m0_alu_op;

  int  checks = 0;
  int  errors = 0;
  cw_t sb[$];

  always #5 clk = ~clk;

  ctrl_pipe #(.LOAD_LAT(2), .EN_M(1), .DIV_CYCLES(8), .FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .b(b), .out_valid(out_valid), .imm_type(imm_type), .alu1_sel(alu1_sel),
    .alu2_sel(alu2_sel), .rd_sel(rd_sel), .alu_op(alu_op), .reg_wr(reg_wr),
    .we(we), .pc_sel(pc_sel), .flush(flush), .illegal(illegal)
  );

  ctrl_pipe #(.LOAD_LAT(2), .EN_M(0), .DIV_CYCLES(8), .FLUSH_DEPTH(2)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m0_in_ready),
    .opcode(opcode), .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .b(b), .out_valid(m0_out_valid), .imm_type(m0_imm_type), .alu1_sel(m0_alu1_sel),
    .alu2_sel(m0_alu2_sel), .rd_sel(m0_rd_sel), .alu_op(m0_alu_op), .reg_wr(m0_reg_wr),
    .we(m0_we), .pc_sel(m0_pc_sel), .flush(m0_flush), .illegal(m0_illegal)
  );

  function automatic cw_t mk(input logic [2:0] it, input logic a1, input logic a2,
                             input logic [1:0] rs, input logic [3:0] op,
                             input logic rw, input logic w);
    return {it, a1, a2, rs, op, rw, w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then retire any committed control word against the queue.
  task automatic tick();
    cw_t e;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      chk("commit_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("commit_word", {imm_type, alu1_sel, alu2_sel, rd_sel, alu_op, reg_wr, we}, e);
      end
    end
  endtask

  task automatic slot(input logic v, input logic [4:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rdv, input logic [4:0] r1,
                      input logic [4:0] r2);
    in_valid = v; opcode = opc; func3 = f3; func7 = f7; rd = rdv; rs1 = r1; rs2 = r2;
  endtask

  task automatic issue(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic exp_rdy, input logic push, input cw_t exp);
    slot(1'b1, opc, f3, f7, rdv, r1, r2);
    #1;
    chk("in_ready", in_ready, exp_rdy);
    if (push) sb.push_back(exp);
    tick();
  endtask

  task automatic idle();
    slot(1'b0, 5'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
  endtask

  task automatic chk_reset_outputs();
    chk("reset_outputs",
        {out_valid, reg_wr, we, pc_sel, flush, illegal, imm_type, alu1_sel, alu2_sel,
         rd_sel, alu_op, in_ready},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0});
  endtask

  initial begin
    b   = 1'b0;
    rst = 1'b0;
    slot(1'b0, 5'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    chk_reset_outputs();
    rst = 1'b1;
    #1;
    chk("ready_after_reset", in_ready, 1);

    // Basic decodes, back to back
    issue(OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 1, 1, mk(3'd0, 0, 1, 2'd0, 4'd0, 1, 0));
    chk("addi_out_valid", out_valid, 1);
    issue(OPC_LUI,    3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 1, 1, mk(3'd3, 0, 1, 2'd1, 4'd15, 1, 0));
    issue(OPC_AUIPC,  3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 1, 1, mk(3'd3, 1, 1, 2'd0, 4'd0, 1, 0));
    issue(OPC_STORE,  3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 1, 1, mk(3'd1, 0, 1, 2'd0, 4'd0, 0, 1));
    issue(OPC_OP,     3'd4, 7'd0, 5'd4, 5'd1, 5'd2, 1, 1, mk(3'd7, 0, 0, 2'd0, 4'd5, 1, 0));
    issue(OPC_OP_IMM, 3'd5, 7'b0100000, 5'd4, 5'd1, 5'd0, 1, 1, mk(3'd0, 0, 1, 2'd0, 4'd7, 1, 0));
    issue(OPC_OP,     3'd3, 7'd0, 5'd4, 5'd1, 5'd2, 1, 1, mk(3'd7, 0, 0, 2'd0, 4'd4, 1, 0));
    issue(OPC_OP,     3'd0, 7'b0000001, 5'd4, 5'd1, 5'd2, 1, 1, mk(3'd7, 0, 0, 2'd0, 4'd10, 1, 0));
    chk("nom_mul_illegal", {m0_illegal, m0_out_valid, m0_reg_wr}, 3'b100);
    issue(5'b11111,   3'd0, 7'd0, 5'd4, 5'd1, 5'd2, 1, 0, '0);
    chk("unknown_illegal", {illegal, out_valid, reg_wr}, 3'b100);
    idle();

    // Load-use stall, LOAD_LAT=2
    issue(OPC_LOAD, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 1, 1, mk(3'd0, 0, 1, 2'd3, 4'd0, 1, 0));
    issue(OPC_OP, 3'd0, 7'd0, 5'd6, 5'd5, 5'd3, 0, 0, '0);
    chk("ld_wait_out_valid", out_valid, 0);
    issue(OPC_OP, 3'd0, 7'd0, 5'd6, 5'd5, 5'd3, 0, 0, '0);
    chk("ld_bubble_out_valid", out_valid, 0);
    issue(OPC_OP, 3'd0, 7'd0, 5'd6, 5'd5, 5'd3, 1, 1, mk(3'd7, 0, 0, 2'd0, 4'd0, 1, 0));
    chk("add_after_load", out_valid, 1);
    // rd=0 never creates a hazard
    issue(OPC_LOAD, 3'd2, 7'd0, 5'd0, 5'd1, 5'd0, 1, 1, mk(3'd0, 0, 1, 2'd3, 4'd0, 1, 0));
    issue(OPC_OP, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 1, 1, mk(3'd7, 0, 0, 2'd0, 4'd0, 1, 0));
    idle();

    // DIVU occupies execute for 8 cycles
    issue(OPC_OP, 3'd5, 7'b0000001, 5'd7, 5'd1, 5'd2, 1, 1, mk(3'd7, 0, 0, 2'd0, 4'd12, 1, 0));
    chk("nom_divu_illegal", {m0_illegal, m0_reg_wr, m0_out_valid}, 3'b100);
    for (int i = 0; i < 7; i++) begin
      slot(1'b1, OPC_OP_IMM, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0);
      #1;
      chk("div_busy_ready", in_ready, 0);
      chk("div_busy_out_valid", out_valid, 0);
      tick();
    end
    chk("divu_commit", {out_valid, alu_op}, {1'b1, 4'd12});
    issue(OPC_OP_IMM, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 1, 1, mk(3'd0, 0, 1, 2'd0, 4'd0, 1, 0));
    idle();

    // Taken branch, FLUSH_DEPTH=2
    issue(OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 1, 1, mk(3'd2, 1, 1, 2'd0, 4'd0, 0, 0));
    b = 1'b1;
    slot(1'b1, OPC_OP_IMM, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0);
    #1;
    chk("taken_pc_sel_flush_ready", {pc_sel, flush, in_ready}, 3'b111);
    tick();
    b = 1'b0;
    #1;
    chk("flush2_pc_sel_flush_ready", {pc_sel, flush, in_ready}, 3'b011);
    chk("flush2_out_valid", out_valid, 0);
    tick();
    chk("after_flush_out_valid", {out_valid, flush}, 2'b00);
    issue(OPC_OP_IMM, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 1, 1, mk(3'd0, 0, 1, 2'd0, 4'd0, 1, 0));
    idle();

    // Not-taken branch
    issue(OPC_BRANCH, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 1, 1, mk(3'd2, 1, 1, 2'd0, 4'd0, 0, 0));
    slot(1'b1, OPC_OP_IMM, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0);
    #1;
    chk("not_taken_pc_sel_flush", {pc_sel, flush}, 2'b00);
    issue(OPC_OP_IMM, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 1, 1, mk(3'd0, 0, 1, 2'd0, 4'd0, 1, 0));
    idle();

    // Redirect wins over a slot reading the earlier load's rd
    issue(OPC_LOAD, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 1, 1, mk(3'd0, 0, 1, 2'd3, 4'd0, 1, 0));
    issue(OPC_JAL, 3'd0, 7'd0, 5'd1, 5'd5, 5'd5, 1, 1, mk(3'd4, 1, 1, 2'd2, 4'd0, 1, 0));
    slot(1'b1, OPC_OP, 3'd0, 7'd0, 5'd6, 5'd5, 5'd5);
    #1;
    chk("jal_flush_ready", {pc_sel, flush, in_ready}, 3'b111);
    tick();
    #1;
    chk("jal_flush2_ready", {flush, in_ready}, 2'b11);
    tick();
    #1;
    chk("jal_no_ld_wait", {flush, in_ready, out_valid}, 3'b010);
    idle();

    // Reset during a divide
    issue(OPC_OP, 3'd4, 7'b0000001, 5'd7, 5'd1, 5'd2, 1, 0, '0);
    idle();
    idle();
    idle();
    rst = 1'b0;
    tick();
    chk_reset_outputs();
    rst = 1'b1;
    #1;
    chk("ready_after_div_reset", in_ready, 1);
    issue(OPC_OP, 3'd0, 7'b0100000, 5'd3, 5'd1, 5'd2, 1, 1, mk(3'd7, 0, 0, 2'd0, 4'd1, 1, 0));
    chk("sub_commit", {out_valid, alu_op}, {1'b1, 4'd1});
    idle();
    idle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
